// File: rtl/alu_control_seq.sv
// ============================================================================
//  Module      : alu_control_seq
//  Description : Decodes ALU requests into aluControl beats. A shift request
//                expands into one beat per bit of shift amount.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_control_seq #(
    parameter int FUNC_W   = 3,
    parameter int SHAMT_W  = 4,
    parameter int CTRL_W   = 4,
    parameter int NOP_CODE = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         aluOp,
    input  logic [FUNC_W-1:0]  func,
    input  logic               shiftDirection,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  aluControl,
    output logic               out_last,
    output logic               illegal
);

    // The func field never reaches the aluControl MSB.
    localparam int c_FUNC_BITS = (FUNC_W < CTRL_W - 1) ? FUNC_W : CTRL_W - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_stateNext;
    logic [CTRL_W-1:0]   r_aluControl;
    logic                r_outLast;
    logic                r_illegal;
    logic [SHAMT_W-1:0]  r_count;

    logic                w_outValid;
    logic                w_accept;
    logic                w_consume;
    logic                w_isShift;
    logic                w_isIllegal;
    logic                w_multiBeat;
    logic [CTRL_W-1:0]   w_decoded;

    assign w_outValid = (r_state != IDLE);
    assign w_consume  = w_outValid && out_ready;
    assign in_ready   = rst_n && (!w_outValid || (w_outValid && out_ready && r_outLast));
    assign w_accept   = in_valid && in_ready;

    assign out_valid  = w_outValid;
    assign aluControl = r_aluControl;
    assign out_last   = r_outLast;
    assign illegal    = r_illegal;

    always_comb begin
        w_decoded   = '0;
        w_isShift   = 1'b0;
        w_isIllegal = 1'b0;
        case (aluOp)
            3'd0: w_decoded = CTRL_W'(0);
            3'd1: w_decoded = CTRL_W'(1);
            3'd2: w_decoded = {{(CTRL_W - c_FUNC_BITS){1'b0}}, func[c_FUNC_BITS-1:0]};
            3'd3: begin
                w_isShift = 1'b1;
                w_decoded = shiftDirection ? CTRL_W'(6) : CTRL_W'(7);
            end
            3'd4: begin
                w_isShift = 1'b1;
                w_decoded = CTRL_W'(8);
            end
            default: w_isIllegal = 1'b1;
        endcase
        // A zero-length shift still produces one beat, as a no-op.
        if (w_isShift && (shamt == '0)) begin
            w_decoded = CTRL_W'(NOP_CODE);
        end
    end

    assign w_multiBeat = w_isShift && (shamt > SHAMT_W'(1));

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_stateNext = w_multiBeat ? SHIFT : EMIT;
                end
            end
            EMIT: begin
                if (w_accept) begin
                    w_stateNext = w_multiBeat ? SHIFT : EMIT;
                end else if (w_consume) begin
                    w_stateNext = IDLE;
                end
            end
            SHIFT: begin
                if (w_consume && (r_count == SHAMT_W'(2))) begin
                    w_stateNext = EMIT;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // r_count holds the beats still to be presented, including the current one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aluControl <= '0;
            r_outLast    <= 1'b0;
            r_illegal    <= 1'b0;
            r_count      <= '0;
        end else if (w_accept) begin
            r_aluControl <= w_decoded;
            r_outLast    <= !w_multiBeat;
            r_illegal    <= w_isIllegal;
            r_count      <= shamt;
        end else if (w_consume && (r_state == SHIFT)) begin
            r_count      <= r_count - SHAMT_W'(1);
            r_outLast    <= (r_count == SHAMT_W'(2));
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_control_seq.sv
// ============================================================================
//  Module      : tb_alu_control_seq
//  Description : Self-checking bench for alu_control_seq: directed cases plus
//                randomized traffic against a queue-of-beats reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_control_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] aluOp;
    logic [2:0] func;
    logic       shiftDirection;
    logic [3:0] shamt;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] aluControl;
    logic       out_last;
    logic       illegal;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct packed {
        logic [3:0] ctrl;
        logic       last;
        logic       ill;
    } beat_t;

    beat_t expQ[$];

    alu_control_seq #(
        .FUNC_W  (3),
        .SHAMT_W (4),
        .CTRL_W  (4),
        .NOP_CODE(15)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .aluOp         (aluOp),
        .func          (func),
        .shiftDirection(shiftDirection),
        .shamt         (shamt),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .aluControl    (aluControl),
        .out_last      (out_last),
        .illegal       (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: every accepted request becomes a list of beats in a queue.
    task automatic pushRequest(input logic [2:0] op, input logic [2:0] fn,
                               input logic dir, input logic [3:0] n);
        beat_t b;
        if (op == 3'd3 || op == 3'd4) begin
            if (n == 0) begin
                b = '{ctrl: 4'd15, last: 1'b1, ill: 1'b0};
                expQ.push_back(b);
            end else begin
                for (int k = 1; k <= int'(n); k++) begin
                    b.ctrl = (op == 3'd4) ? 4'd8 : (dir ? 4'd6 : 4'd7);
                    b.last = (k == int'(n));
                    b.ill  = 1'b0;
                    expQ.push_back(b);
                end
            end
        end else if (op >= 3'd5) begin
            b = '{ctrl: 4'd0, last: 1'b1, ill: 1'b1};
            expQ.push_back(b);
        end else begin
            b.ctrl = (op == 3'd2) ? {1'b0, fn} : {1'b0, op};
            b.last = 1'b1;
            b.ill  = 1'b0;
            expQ.push_back(b);
        end
    endtask

    // Compare process: check at the falling edge, advance the model at the rising edge.
    initial begin
        logic       expReady;
        logic       doAccept;
        logic       doConsume;
        logic [2:0] sOp;
        logic [2:0] sFn;
        logic       sDir;
        logic [3:0] sN;
        forever begin
            @(negedge clk);
            doAccept  = 1'b0;
            doConsume = 1'b0;
            if (!rst_n) begin
                expQ.delete();
                check("rst out_valid", int'(out_valid), 0);
                check("rst in_ready", int'(in_ready), 0);
                check("rst aluControl", int'(aluControl), 0);
                check("rst out_last", int'(out_last), 0);
                check("rst illegal", int'(illegal), 0);
            end else begin
                expReady = (expQ.size() == 0) || (out_ready && expQ[0].last);
                check("out_valid", int'(out_valid), int'(expQ.size() != 0));
                check("in_ready", int'(in_ready), int'(expReady));
                if (expQ.size() != 0) begin
                    check("aluControl", int'(aluControl), int'(expQ[0].ctrl));
                    check("out_last", int'(out_last), int'(expQ[0].last));
                    check("illegal", int'(illegal), int'(expQ[0].ill));
                end
                doConsume = (expQ.size() != 0) && out_ready;
                doAccept  = in_valid && expReady;
                sOp = aluOp; sFn = func; sDir = shiftDirection; sN = shamt;
            end
            @(posedge clk);
            if (!rst_n) begin
                expQ.delete();
            end else begin
                if (doConsume) void'(expQ.pop_front());
                if (doAccept) pushRequest(sOp, sFn, sDir, sN);
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; aluOp = 3'd0; func = 3'd0;
        shiftDirection = 1'b0; shamt = 4'd0; out_ready = 1'b1;
        repeat (3) tick();
        check("reset valid", int'(out_valid), 0);
        check("reset ready", int'(in_ready), 0);
        check("reset ctrl", int'(aluControl), 0);
        rst_n = 1'b1;

        // R-type, accepted on the first edge after reset release.
        in_valid = 1'b1; aluOp = 3'd2; func = 3'd5;
        tick();
        in_valid = 1'b0; func = 3'd2;
        check("rtype valid", int'(out_valid), 1);
        check("rtype ctrl", int'(aluControl), 5);
        check("rtype last", int'(out_last), 1);
        tick();
        check("rtype done", int'(out_valid), 0);

        // Right shift by 3; fields change after acceptance.
        in_valid = 1'b1; aluOp = 3'd3; shiftDirection = 1'b1; shamt = 4'd3;
        tick();
        in_valid = 1'b0; shiftDirection = 1'b0; shamt = 4'd9;
        check("sr beat1 ctrl", int'(aluControl), 6);
        check("sr beat1 last", int'(out_last), 0);
        check("sr beat1 ready", int'(in_ready), 0);
        tick();
        check("sr beat2 ctrl", int'(aluControl), 6);
        check("sr beat2 last", int'(out_last), 0);
        tick();
        check("sr beat3 ctrl", int'(aluControl), 6);
        check("sr beat3 last", int'(out_last), 1);
        check("sr beat3 ready", int'(in_ready), 1);
        tick();
        check("sr done", int'(out_valid), 0);

        // Zero-length shift.
        in_valid = 1'b1; aluOp = 3'd4; shamt = 4'd0;
        tick();
        in_valid = 1'b0;
        check("nop ctrl", int'(aluControl), 15);
        check("nop last", int'(out_last), 1);
        tick();

        // Left shift by 2 with back-pressure after the first beat.
        in_valid = 1'b1; aluOp = 3'd3; shiftDirection = 1'b0; shamt = 4'd2;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall ctrl", int'(aluControl), 7);
            check("stall last", int'(out_last), 0);
            check("stall ready", int'(in_ready), 0);
            tick();
        end
        out_ready = 1'b1;
        check("stall beat1", int'(aluControl), 7);
        tick();
        check("stall beat2 ctrl", int'(aluControl), 7);
        check("stall beat2 last", int'(out_last), 1);
        tick();
        check("stall done", int'(out_valid), 0);

        // Illegal opcode.
        in_valid = 1'b1; aluOp = 3'd6;
        tick();
        in_valid = 1'b0;
        check("ill ctrl", int'(aluControl), 0);
        check("ill flag", int'(illegal), 1);
        check("ill last", int'(out_last), 1);
        tick();

        // Reset in the middle of a 15-beat shift.
        in_valid = 1'b1; aluOp = 3'd3; shiftDirection = 1'b1; shamt = 4'd15;
        tick();
        in_valid = 1'b0;
        tick();
        check("mid beat2 valid", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("mid rst valid", int'(out_valid), 0);
        check("mid rst ready", int'(in_ready), 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post rst idle", int'(out_valid), 0);
        end

        // Randomized traffic, with occasional reset pulses.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            in_valid       = ($urandom_range(0, 9) < 7);
            aluOp          = 3'($urandom_range(0, 7));
            func           = 3'($urandom);
            shiftDirection = 1'($urandom);
            shamt          = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 2))
                                                         : 4'($urandom);
            out_ready      = ($urandom_range(0, 3) != 0);
            rst_n          = ($urandom_range(0, 399) != 0);
            tick();
        end
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

`default_nettype wire
